// File: rtl/uart_cmd_sender_pkg.sv
// Shared definitions for the UART heater-command protocol: opcodes, wire bytes, status codes.
// The command decoder on the remote side imports the same byte tables.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    OP_START       = 4'd0,
    OP_STOP        = 4'd1,
    OP_WRITE_SET   = 4'd2,
    OP_READ_SET    = 4'd3,
    OP_RW          = 4'd4,
    OP_QR          = 4'd5,
    OP_QW          = 4'd6,
    OP_ADDR_INC    = 4'd7,
    OP_ADDR_STATIC = 4'd8,
    OP_RESET       = 4'd9,
    OP_PORT_MASK   = 4'd10,
    OP_LENGTH      = 4'd11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBadAck  = 2'd1,
    ErrTimeout = 2'd2,
    ErrBadOp   = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {StIdle, StSend, StWaitLo, StWaitAck, StFinish} state_t;

  localparam logic [7:0] CmdStart      = 8'h30, AckStart      = 8'h41;
  localparam logic [7:0] CmdStop       = 8'h31, AckStop       = 8'h42;
  localparam logic [7:0] CmdWriteSet   = 8'h32, AckWriteSet   = 8'h43;
  localparam logic [7:0] CmdReadSet    = 8'h33, AckReadSet    = 8'h44;
  localparam logic [7:0] CmdRw         = 8'h34, AckRw         = 8'h45;
  localparam logic [7:0] CmdQr         = 8'h35, AckQr         = 8'h46;
  localparam logic [7:0] CmdQw         = 8'h36, AckQw         = 8'h47;
  localparam logic [7:0] CmdAddrInc    = 8'h37, AckAddrInc    = 8'h48;
  localparam logic [7:0] CmdAddrStatic = 8'h38, AckAddrStatic = 8'h49;
  localparam logic [7:0] CmdPortMask   = 8'h39, AckPortMask   = 8'h4A;
  localparam logic [7:0] CmdLength     = 8'h3A, AckLength     = 8'h4C;
  localparam logic [7:0] CmdReset      = 8'h40, AckReset      = 8'h4B;
  localparam logic [7:0] ErrChar       = 8'h3F;

  function automatic logic op_known(logic [3:0] op);
    return op <= OP_LENGTH;
  endfunction

  function automatic logic [7:0] cmd_byte(logic [3:0] op);
    logic [7:0] b;
    case (op)
      OP_START:       b = CmdStart;
      OP_STOP:        b = CmdStop;
      OP_WRITE_SET:   b = CmdWriteSet;
      OP_READ_SET:    b = CmdReadSet;
      OP_RW:          b = CmdRw;
      OP_QR:          b = CmdQr;
      OP_QW:          b = CmdQw;
      OP_ADDR_INC:    b = CmdAddrInc;
      OP_ADDR_STATIC: b = CmdAddrStatic;
      OP_RESET:       b = CmdReset;
      OP_PORT_MASK:   b = CmdPortMask;
      OP_LENGTH:      b = CmdLength;
      default:        b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ack_byte(logic [3:0] op);
    logic [7:0] b;
    case (op)
      OP_START:       b = AckStart;
      OP_STOP:        b = AckStop;
      OP_WRITE_SET:   b = AckWriteSet;
      OP_READ_SET:    b = AckReadSet;
      OP_RW:          b = AckRw;
      OP_QR:          b = AckQr;
      OP_QW:          b = AckQw;
      OP_ADDR_INC:    b = AckAddrInc;
      OP_ADDR_STATIC: b = AckAddrStatic;
      OP_RESET:       b = AckReset;
      OP_PORT_MASK:   b = AckPortMask;
      OP_LENGTH:      b = AckLength;
      default:        b = ErrChar;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_sender_if.sv
// Command handshake and status bundle between a host and uart_cmd_sender.
interface uart_cmd_sender_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_port_mask;
    logic [3:0]  cmd_length;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, cmd_port_mask, cmd_length,
        input  cmd_ready, done, err, err_code, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_port_mask, cmd_length,
        output cmd_ready, done, err, err_code, busy
    );
endinterface

// File: rtl/uart_ack_timer.sv
// Ack timeout counter: cleared on WAIT_ACK entry, counts idle cycles, flags the last allowed one.
module uart_ack_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Expired marks the TIMEOUT_CYCLES-th idle cycle, so the FSM leaves on that edge.
    assign expired_o = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_cmd_sender.sv
// Initiator side of the heater UART protocol: sends one command's bytes through tx,
// then waits for the single ack byte on rx and reports done or err.
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_cmd_sender_if.slave   cmd_if,
    output logic [7:0]         tx_din_o,
    output logic               tx_send_o,
    input  logic               tx_sent_i,
    input  logic               rx_receive_i,
    input  logic [7:0]         rx_dout_i,
    output logic               rx_received_o
);
    state_t          state_q, state_d;
    logic [4:0][7:0] buf_q, buf_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      n_q, n_d;
    logic [7:0]      ack_q, ack_d;
    err_code_t       code_q, code_d;
    logic            ok_q, ok_d;
    logic            skip_q;
    logic            accept, rx_fire;
    logic            to_clr, to_en, to_expired;

    assign accept = cmd_if.cmd_valid && cmd_if.cmd_ready;
    // One-cycle holdoff after each pop lets the rx drop its level; FINISH leaves bytes for IDLE.
    assign rx_fire = rx_receive_i && !skip_q && (state_q != StFinish);

    assign rx_received_o    = rx_fire;
    assign tx_send_o        = (state_q == StSend);
    assign tx_din_o         = (state_q == StSend) ? buf_q[idx_q] : 8'h00;
    assign cmd_if.cmd_ready = (state_q == StIdle) && rst_ni;
    assign cmd_if.busy      = (state_q != StIdle);
    assign cmd_if.done      = (state_q == StFinish) && ok_q;
    assign cmd_if.err       = (state_q == StFinish) && !ok_q;
    assign cmd_if.err_code  = code_q;

    uart_ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (to_clr),
        .en_i      (to_en),
        .expired_o (to_expired)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        n_d     = n_q;
        ack_d   = ack_q;
        code_d  = code_q;
        ok_d    = ok_q;
        to_clr  = 1'b0;
        to_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    code_d = ErrNone;
                    idx_d  = '0;
                    if (op_known(cmd_if.cmd_op)) begin
                        buf_d    = '0;
                        buf_d[0] = cmd_byte(cmd_if.cmd_op);
                        ack_d    = ack_byte(cmd_if.cmd_op);
                        n_d      = 3'd1;
                        if (cmd_if.cmd_op == OP_PORT_MASK) begin
                            buf_d[1] = cmd_if.cmd_port_mask[31:24];
                            buf_d[2] = cmd_if.cmd_port_mask[23:16];
                            buf_d[3] = cmd_if.cmd_port_mask[15:8];
                            buf_d[4] = cmd_if.cmd_port_mask[7:0];
                            n_d      = 3'd5;
                        end else if (cmd_if.cmd_op == OP_LENGTH) begin
                            buf_d[1] = {4'h0, cmd_if.cmd_length};
                            n_d      = 3'd2;
                        end
                        state_d = StSend;
                    end else begin
                        code_d  = ErrBadOp;
                        ok_d    = 1'b0;
                        state_d = StFinish;
                    end
                end
            end
            StSend: begin
                if (tx_sent_i) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!tx_sent_i) begin
                    if (idx_q < (n_q - 3'd1)) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end else begin
                        to_clr  = 1'b1;
                        state_d = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                // A byte arriving on the expiry cycle still gets judged on its value.
                if (rx_fire) begin
                    ok_d    = (rx_dout_i == ack_q);
                    code_d  = (rx_dout_i == ack_q) ? ErrNone : ErrBadAck;
                    state_d = StFinish;
                end else if (to_expired) begin
                    ok_d    = 1'b0;
                    code_d  = ErrTimeout;
                    state_d = StFinish;
                end else begin
                    to_en = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            ack_q   <= '0;
            code_q  <= ErrNone;
            ok_q    <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ack_q   <= ack_d;
            code_q  <= code_d;
            ok_q    <= ok_d;
            skip_q  <= rx_fire;
        end
    end
endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench for uart_cmd_sender: tx/rx peer models, a table-driven reference model,
// and a negedge monitor that checks every done/err pulse against queued expectations.
module tb_uart_cmd_sender;
    localparam int unsigned TO = 50;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        logic       chk_lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_din;
    logic       tx_send;
    logic       tx_sent;
    logic       rx_receive;
    logic [7:0] rx_dout;
    logic       rx_received;

    uart_cmd_sender_if cmd_if ();

    uart_cmd_sender #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_if        (cmd_if),
        .tx_din_o      (tx_din),
        .tx_send_o     (tx_send),
        .tx_sent_i     (tx_sent),
        .rx_receive_i  (rx_receive),
        .rx_dout_i     (rx_dout),
        .rx_received_o (rx_received)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_tx_q[$];
    res_t       exp_res_q[$];
    logic [1:0] last_code = 2'd0;
    int         rx_pops = 0;
    logic       popped_flag = 1'b0;
    logic       prev_finish = 1'b0;
    int         last_drop = 0;
    int         bytes_seen = 0;
    int         tx_st = 0;
    int         tx_dly = 0;
    logic [7:0] tx_cap = 8'h00;
    logic       resp_en = 1'b0;
    logic       resp_stray = 1'b0;
    int         resp_target = 0;
    int         resp_dly = 0;
    logic [7:0] resp_byte = 8'h00;
    int         rx_st = 0;

    // Wire bytes and acks straight from the protocol table, indexed by opcode 0..11.
    logic [7:0] cmd_tab [12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                 8'h36, 8'h37, 8'h38, 8'h40, 8'h39, 8'h3A};
    logic [7:0] ack_tab [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                                 8'h47, 8'h48, 8'h49, 8'h4B, 8'h4A, 8'h4C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] mask,
                                      input logic [3:0] len, output logic [7:0] bytes[$],
                                      output logic [7:0] ack, output bit known);
        bytes = {};
        ack   = 8'h00;
        known = (op < 4'd12);
        if (!known) return;
        bytes.push_back(cmd_tab[op]);
        if (op == 4'd10) begin
            for (int k = 3; k >= 0; k--) bytes.push_back(8'(mask >> (8 * k)));
        end else if (op == 4'd11) begin
            bytes.push_back({4'h0, len});
        end
        ack = ack_tab[op];
    endfunction

    // Monitor: sample every DUT output mid-cycle, pop expectations on done/err.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_finish = 1'b0;
            end else begin
                check("ready_vs_busy", 32'(cmd_if.cmd_ready), 32'(!cmd_if.busy));
                if (prev_finish) begin
                    check("ready_after_finish", 32'(cmd_if.cmd_ready), 32'd1);
                    check("single_pulse", 32'(cmd_if.done | cmd_if.err), 32'd0);
                end
                prev_finish = cmd_if.done || cmd_if.err;
                if (cmd_if.done || cmd_if.err) begin
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: done=%0b err=%0b code=%0d, none expected",
                                 cmd_if.done, cmd_if.err, cmd_if.err_code);
                    end else begin
                        r = exp_res_q.pop_front();
                        check("result_err", 32'(cmd_if.err), 32'(r.is_err));
                        check("result_done", 32'(cmd_if.done), 32'(!r.is_err));
                        check("err_code", 32'(cmd_if.err_code), 32'(r.code));
                        if (r.chk_lat) check("timeout_latency", 32'(cyc - last_drop), TO + 1);
                        last_code = r.code;
                    end
                end else if (cmd_if.cmd_ready) begin
                    check("err_code_held", 32'(cmd_if.err_code), 32'(last_code));
                end
                if (rx_received) begin
                    rx_pops++;
                    popped_flag = 1'b1;
                end
            end
        end
    end

    // tx peer and rx responder, stepped once per cycle just after the clock edge.
    initial begin
        tx_sent    = 1'b0;
        rx_receive = 1'b0;
        rx_dout    = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                tx_sent    = 1'b0;
                tx_st      = 0;
                rx_receive = 1'b0;
                rx_st      = 0;
                continue;
            end
            case (tx_st)
                0: if (tx_send) begin
                    tx_cap = tx_din;
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx: got %0h, no byte expected", tx_din);
                    end else begin
                        check("tx_byte", 32'(tx_din), 32'(exp_tx_q.pop_front()));
                    end
                    tx_dly = $urandom_range(0, 3);
                    tx_st  = 1;
                end
                1: begin
                    check("tx_send_held", 32'(tx_send), 32'd1);
                    check("tx_din_stable", 32'(tx_din), 32'(tx_cap));
                    if (tx_dly == 0) begin
                        tx_sent = 1'b1;
                        tx_st   = 2;
                    end else begin
                        tx_dly--;
                    end
                end
                2: if (!tx_send) begin
                    tx_sent    = 1'b0;
                    last_drop  = cyc;
                    bytes_seen++;
                    tx_st      = 0;
                end
                default: tx_st = 0;
            endcase
            case (rx_st)
                0: begin
                    if (resp_stray) begin
                        resp_stray  = 1'b0;
                        rx_receive  = 1'b1;
                        rx_dout     = resp_byte;
                        popped_flag = 1'b0;
                        rx_st       = 2;
                    end else if (resp_en && bytes_seen == resp_target && tx_st == 0 && !tx_sent) begin
                        resp_en = 1'b0;
                        rx_st   = 1;
                    end
                end
                1: begin
                    if (resp_dly == 0) begin
                        rx_receive  = 1'b1;
                        rx_dout     = resp_byte;
                        popped_flag = 1'b0;
                        rx_st       = 2;
                    end else begin
                        resp_dly--;
                    end
                end
                2: if (popped_flag) begin
                    rx_receive = 1'b0;
                    rx_st      = 0;
                end
                default: rx_st = 0;
            endcase
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] mask, input logic [3:0] len);
        int i = 0;
        @(posedge clk);
        #2;
        while (!cmd_if.cmd_ready && i < 100) begin
            @(posedge clk);
            #2;
            i++;
        end
        check("ready_before_issue", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_op        = op;
        cmd_if.cmd_port_mask = mask;
        cmd_if.cmd_length    = len;
        @(posedge clk);
        #2;
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_op        = 4'($urandom);
        cmd_if.cmd_port_mask = $urandom;
        cmd_if.cmd_length    = 4'($urandom);
    endtask

    // kind: 0 correct ack, 1 wrong byte (bad), 2 no answer.
    task automatic run_cmd(input logic [3:0] op, input logic [31:0] mask, input logic [3:0] len,
                           input int kind, input logic [7:0] bad);
        logic [7:0] bytes[$];
        logic [7:0] ack;
        bit         known;
        res_t       r;
        int         pops0;
        int         exp_pops;
        int         i = 0;
        ref_model(op, mask, len, bytes, ack, known);
        foreach (bytes[k]) exp_tx_q.push_back(bytes[k]);
        r.chk_lat = 1'b0;
        if (!known) begin
            r.is_err = 1'b1; r.code = 2'd3;
        end else if (kind == 0) begin
            r.is_err = 1'b0; r.code = 2'd0;
        end else if (kind == 1) begin
            r.is_err = 1'b1; r.code = 2'd1;
        end else begin
            r.is_err = 1'b1; r.code = 2'd2; r.chk_lat = 1'b1;
        end
        exp_res_q.push_back(r);
        resp_byte   = (kind == 0) ? ack : ((bad == ack) ? (bad ^ 8'h01) : bad);
        resp_target = bytes_seen + bytes.size();
        resp_dly    = $urandom_range(0, 5);
        exp_pops    = (known && kind != 2) ? 1 : 0;
        resp_en     = (exp_pops == 1);
        pops0       = rx_pops;
        issue(op, mask, len);
        while (exp_res_q.size() != 0 && i < 4 * TO + 200) begin
            @(posedge clk);
            #2;
            // Requests while busy must be ignored.
            cmd_if.cmd_valid = cmd_if.busy && ($urandom_range(0, 1) == 1);
            i++;
        end
        cmd_if.cmd_valid = 1'b0;
        if (exp_res_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: op %0h got no done/err within %0d cycles", op, i);
            exp_res_q.delete();
            exp_tx_q.delete();
            resp_en = 1'b0;
        end else begin
            check("tx_bytes_consumed", 32'(exp_tx_q.size()), 32'd0);
        end
        repeat (2) @(posedge clk);
        #2;
        check("rx_pops", 32'(rx_pops - pops0), 32'(exp_pops));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pops0;
        int         base;
        int         i;
        int         kind;
        logic [7:0] bad;
        logic [7:0] bytes[$];
        logic [7:0] ack;
        bit         known;
        res_t       r;
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_op        = 4'h0;
        cmd_if.cmd_port_mask = 32'h0;
        cmd_if.cmd_length    = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_din", 32'(tx_din), 32'd0);
        check("rst_rx_received", 32'(rx_received), 32'd0);
        check("rst_done", 32'(cmd_if.done), 32'd0);
        check("rst_err", 32'(cmd_if.err), 32'd0);
        check("rst_err_code", 32'(cmd_if.err_code), 32'd0);
        check("rst_busy", 32'(cmd_if.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);

        run_cmd(4'd0, 32'h0, 4'h0, 0, 8'h00);
        run_cmd(4'd10, 32'hDEADBEEF, 4'h0, 0, 8'h00);
        run_cmd(4'd11, 32'h0, 4'h7, 1, 8'h3F);
        run_cmd(4'd1, 32'h0, 4'h0, 2, 8'h00);
        run_cmd(4'hE, 32'h0, 4'h0, 0, 8'h00);

        // Stray byte while idle: popped once, no status change.
        pops0      = rx_pops;
        resp_byte  = 8'h55;
        resp_stray = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("stray_pop", 32'(rx_pops - pops0), 32'd1);
        check("stray_idle", 32'(cmd_if.busy), 32'd0);

        // Abort PORT_MASK during its third byte.
        ref_model(4'd10, 32'hCAFEF00D, 4'h0, bytes, ack, known);
        foreach (bytes[k]) exp_tx_q.push_back(bytes[k]);
        r.is_err = 1'b0; r.code = 2'd0; r.chk_lat = 1'b0;
        exp_res_q.push_back(r);
        resp_en = 1'b0;
        base = bytes_seen;
        issue(4'd10, 32'hCAFEF00D, 4'h0);
        i = 0;
        while (!(bytes_seen >= base + 2 && tx_send) && i < 200) begin
            @(posedge clk);
            #2;
            i++;
        end
        check("abort_third_byte", 32'(tx_send), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_send", 32'(tx_send), 32'd0);
        check("abort_tx_din", 32'(tx_din), 32'd0);
        check("abort_rx_received", 32'(rx_received), 32'd0);
        check("abort_done", 32'(cmd_if.done), 32'd0);
        check("abort_err", 32'(cmd_if.err), 32'd0);
        check("abort_err_code", 32'(cmd_if.err_code), 32'd0);
        check("abort_busy", 32'(cmd_if.busy), 32'd0);
        check("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
        exp_tx_q.delete();
        exp_res_q.delete();
        last_code = 2'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_cmd(4'd9, 32'h0, 4'h0, 0, 8'h00);

        for (int n = 0; n < 40; n++) begin
            i    = $urandom_range(0, 9);
            kind = (i < 6) ? 0 : ((i < 8) ? 1 : 2);
            bad  = ($urandom_range(0, 1) == 1) ? 8'h3F : 8'($urandom);
            run_cmd(4'($urandom_range(0, 15)), $urandom, 4'($urandom), kind, bad);
        end

        check("final_tx_queue", 32'(exp_tx_q.size()), 32'd0);
        check("final_res_queue", 32'(exp_res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
